// File: rtl/sprite_addr_gen_pkg.sv
// Shared widths, screen constants and the window configuration record
// used by the sprite window-to-ROM address generator.
package sprite_addr_gen_pkg;

  localparam int CNT_W  = 10;
  localparam int SZ_W   = 8;
  localparam int ADDR_W = 15;
  localparam int SC_W   = 2;

  localparam int H_VIS = 640;
  localparam int V_VIS = 480;

  typedef struct packed {
    logic              en;
    logic [CNT_W-1:0]  x;
    logic [CNT_W-1:0]  y;
    logic [SZ_W-1:0]   w;
    logic [SZ_W-1:0]   h;
    logic [SC_W-1:0]   scale;
    logic [ADDR_W-1:0] base;
  } win_cfg_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_addr_gen_if.sv
// Window configuration write bus: shadow-register writes in, pending flag out.
interface sprite_addr_gen_if
  import sprite_addr_gen_pkg::*;
#(
  parameter int IDX_W = 2
);

  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic              cfg_en;
  logic [CNT_W-1:0]  cfg_x;
  logic [CNT_W-1:0]  cfg_y;
  logic [SZ_W-1:0]   cfg_w;
  logic [SZ_W-1:0]   cfg_h;
  logic [SC_W-1:0]   cfg_scale;
  logic [ADDR_W-1:0] cfg_base;
  logic              cfg_pending;

  modport master (
    output cfg_we, cfg_idx, cfg_en, cfg_x, cfg_y, cfg_w, cfg_h, cfg_scale, cfg_base,
    input  cfg_pending
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_en, cfg_x, cfg_y, cfg_w, cfg_h, cfg_scale, cfg_base,
    output cfg_pending
  );

endinterface

// File: rtl/sprite_win_hit.sv
// Stage 1 for one window: coverage test of the raster position and
// source row/column, registered together with the fields stage 2 needs.
module sprite_win_hit
  import sprite_addr_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [CNT_W-1:0]  h_cnt,
  input  logic [CNT_W-1:0]  v_cnt,
  input  win_cfg_t          win,
  output logic              in_q,
  output logic [SZ_W-1:0]   row_q,
  output logic [SZ_W-1:0]   col_q,
  output logic [SZ_W-1:0]   w_q,
  output logic [ADDR_W-1:0] base_q
);

  localparam int EW = CNT_W + 1;
  // One extra bit over the extent so the far edge clips instead of wrapping.
  localparam int SW = CNT_W + 2;

  logic [EW-1:0]     ext_w;
  logic [EW-1:0]     ext_h;
  logic              h_in;
  logic              v_in;
  logic              in_d;
  logic [SZ_W-1:0]   row_d;
  logic [SZ_W-1:0]   col_d;
  logic [SZ_W-1:0]   w_d;
  logic [ADDR_W-1:0] base_d;

  always_comb begin
    ext_w  = EW'(win.w) << win.scale;
    ext_h  = EW'(win.h) << win.scale;
    h_in   = (h_cnt >= win.x) && (SW'(h_cnt) < (SW'(win.x) + SW'(ext_w)));
    v_in   = (v_cnt >= win.y) && (SW'(v_cnt) < (SW'(win.y) + SW'(ext_h)));
    in_d   = win.en && valid && h_in && v_in;
    col_d  = SZ_W'((h_cnt - win.x) >> win.scale);
    row_d  = SZ_W'((v_cnt - win.y) >> win.scale);
    w_d    = win.w;
    base_d = win.base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q   <= 1'b0;
      row_q  <= '0;
      col_q  <= '0;
      w_q    <= '0;
      base_q <= '0;
    end else begin
      in_q   <= in_d;
      row_q  <= row_d;
      col_q  <= col_d;
      w_q    <= w_d;
      base_q <= base_d;
    end
  end

endmodule

// File: rtl/sprite_addr_gen.sv
// Maps the raster position into N_WIN programmable windows and produces a
// registered ROM pixel address two cycles later; config commits at frame start.
module sprite_addr_gen
  import sprite_addr_gen_pkg::*;
#(
  parameter  int N_WIN = 4,
  localparam int IDX_W = idx_width(N_WIN)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid,
  input  logic [CNT_W-1:0]    h_cnt,
  input  logic [CNT_W-1:0]    v_cnt,
  input  logic                frame_start,
  sprite_addr_gen_if.slave    cfg,
  output logic                pixel_valid,
  output logic                hit,
  output logic [IDX_W-1:0]    win_id,
  output logic [ADDR_W-1:0]   pixel_addr
);

  win_cfg_t shadow_q [N_WIN];
  win_cfg_t shadow_d [N_WIN];
  win_cfg_t active_q [N_WIN];
  win_cfg_t active_d [N_WIN];
  win_cfg_t wr_cfg;
  logic     pending_q;
  logic     pending_d;

  // Commit reads the pre-write shadow, so a coincident write stays pending.
  always_comb begin
    wr_cfg = '{en: cfg.cfg_en, x: cfg.cfg_x, y: cfg.cfg_y, w: cfg.cfg_w,
               h: cfg.cfg_h, scale: cfg.cfg_scale, base: cfg.cfg_base};
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (frame_start && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (cfg.cfg_we && (32'(cfg.cfg_idx) < 32'(N_WIN))) begin
      shadow_d[cfg.cfg_idx] = wr_cfg;
      pending_d             = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_WIN; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign cfg.cfg_pending = pending_q;

  logic [N_WIN-1:0]  win_in;
  logic [SZ_W-1:0]   win_row  [N_WIN];
  logic [SZ_W-1:0]   win_col  [N_WIN];
  logic [SZ_W-1:0]   win_w    [N_WIN];
  logic [ADDR_W-1:0] win_base [N_WIN];

  for (genvar g = 0; g < N_WIN; g++) begin : g_win
    sprite_win_hit u_hit (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid  (valid),
      .h_cnt  (h_cnt),
      .v_cnt  (v_cnt),
      .win    (active_q[g]),
      .in_q   (win_in[g]),
      .row_q  (win_row[g]),
      .col_q  (win_col[g]),
      .w_q    (win_w[g]),
      .base_q (win_base[g])
    );
  end

  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [SZ_W-1:0]   sel_row;
  logic [SZ_W-1:0]   sel_col;
  logic [SZ_W-1:0]   sel_w;
  logic [ADDR_W-1:0] sel_base;
  logic [2*SZ_W-1:0] prod;
  logic              hit_d;
  logic [IDX_W-1:0]  win_id_d;
  logic [ADDR_W-1:0] pixel_addr_d;

  // Lowest-index hit wins; a single multiplier serves the selected window.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_row   = '0;
    sel_col   = '0;
    sel_w     = '0;
    sel_base  = '0;
    for (int unsigned i = 0; i < N_WIN; i++) begin
      if (win_in[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_row   = win_row[i];
        sel_col   = win_col[i];
        sel_w     = win_w[i];
        sel_base  = win_base[i];
      end
    end
    prod         = (2*SZ_W)'(sel_row) * (2*SZ_W)'(sel_w);
    hit_d        = sel_found;
    win_id_d     = sel_idx;
    pixel_addr_d = sel_found ? (sel_base + ADDR_W'(prod) + ADDR_W'(sel_col)) : '0;
  end

  logic              pv1_q;
  logic              pixel_valid_q;
  logic              hit_q;
  logic [IDX_W-1:0]  win_id_q;
  logic [ADDR_W-1:0] pixel_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv1_q         <= 1'b0;
      pixel_valid_q <= 1'b0;
      hit_q         <= 1'b0;
      win_id_q      <= '0;
      pixel_addr_q  <= '0;
    end else begin
      pv1_q         <= valid;
      pixel_valid_q <= pv1_q;
      hit_q         <= hit_d;
      win_id_q      <= win_id_d;
      pixel_addr_q  <= pixel_addr_d;
    end
  end

  assign pixel_valid = pixel_valid_q;
  assign hit         = hit_q;
  assign win_id      = win_id_q;
  assign pixel_addr  = pixel_addr_q;

endmodule

// File: tb/tb_sprite_addr_gen.sv
// Directed bench for sprite_addr_gen: expected outputs are queued when a
// raster position is driven and compared when they emerge two cycles later.
module tb_sprite_addr_gen;
  import sprite_addr_gen_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              valid;
  logic [CNT_W-1:0]  h_cnt;
  logic [CNT_W-1:0]  v_cnt;
  logic              frame_start;
  logic              pixel_valid;
  logic              hit;
  logic [1:0]        win_id;
  logic [ADDR_W-1:0] pixel_addr;

  sprite_addr_gen_if #(.IDX_W(2)) cfg_if ();

  sprite_addr_gen #(.N_WIN(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid       (valid),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .frame_start (frame_start),
    .cfg         (cfg_if),
    .pixel_valid (pixel_valid),
    .hit         (hit),
    .win_id      (win_id),
    .pixel_addr  (pixel_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                due;
    logic              pv;
    logic              hit;
    logic [1:0]        id;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk($sformatf("pixel_valid@%0d", cyc), 32'(pixel_valid), 32'(e.pv));
      chk($sformatf("hit@%0d", cyc),         32'(hit),         32'(e.hit));
      chk($sformatf("win_id@%0d", cyc),      32'(win_id),      32'(e.id));
      chk($sformatf("pixel_addr@%0d", cyc),  32'(pixel_addr),  32'(e.addr));
    end
  endtask

  task automatic pix(input logic v, input int h, input int vv,
                     input logic eh, input int eid, input int ea);
    exp_t e;
    valid = v;
    h_cnt = CNT_W'(h);
    v_cnt = CNT_W'(vv);
    e.due  = cyc + 2;
    e.pv   = v;
    e.hit  = eh;
    e.id   = 2'(eid);
    e.addr = ADDR_W'(ea);
    sb.push_back(e);
    tick();
  endtask

  task automatic idle();
    pix(1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic set_cfg(input int idx, input logic en, input int x, input int y,
                         input int w, input int h, input int sc, input int base);
    cfg_if.cfg_idx   = 2'(idx);
    cfg_if.cfg_en    = en;
    cfg_if.cfg_x     = CNT_W'(x);
    cfg_if.cfg_y     = CNT_W'(y);
    cfg_if.cfg_w     = SZ_W'(w);
    cfg_if.cfg_h     = SZ_W'(h);
    cfg_if.cfg_scale = SC_W'(sc);
    cfg_if.cfg_base  = ADDR_W'(base);
  endtask

  task automatic wr(input int idx, input logic en, input int x, input int y,
                    input int w, input int h, input int sc, input int base);
    set_cfg(idx, en, x, y, w, h, sc, base);
    cfg_if.cfg_we = 1'b1;
    idle();
    cfg_if.cfg_we = 1'b0;
  endtask

  task automatic fs();
    frame_start = 1'b1;
    idle();
    frame_start = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    valid       = 1'b0;
    h_cnt       = '0;
    v_cnt       = '0;
    frame_start = 1'b0;
    cfg_if.cfg_we = 1'b0;
    set_cfg(0, 1'b0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pixel_valid", 32'(pixel_valid), 0);
    chk("rst_hit",         32'(hit), 0);
    chk("rst_win_id",      32'(win_id), 0);
    chk("rst_pixel_addr",  32'(pixel_addr), 0);
    chk("rst_pending",     32'(cfg_if.cfg_pending), 0);
    rst_n = 1'b1;

    // Nothing enabled yet
    pix(1'b1, 61, 62, 1'b0, 0, 0);

    // Window 0, visible only after commit
    wr(0, 1'b1, 60, 60, 180, 160, 0, 0);
    chk("pending_after_wr0", 32'(cfg_if.cfg_pending), 1);
    pix(1'b1, 61, 62, 1'b0, 0, 0);
    fs();
    chk("pending_after_fs0", 32'(cfg_if.cfg_pending), 0);
    pix(1'b1, 61, 62, 1'b1, 0, 361);
    pix(1'b1, 240, 62, 1'b0, 0, 0);
    pix(1'b1, 239, 219, 1'b1, 0, 28799);
    pix(1'b1, 239, 220, 1'b0, 0, 0);

    // Window 1, scale 2x
    wr(1, 1'b1, 100, 280, 25, 25, 1, 28800);
    fs();
    pix(1'b1, 103, 285, 1'b1, 1, 28851);
    pix(1'b1, 149, 329, 1'b1, 1, 29424);
    pix(1'b1, 150, 330, 1'b0, 0, 0);

    // Overlap: lower index wins, then window 0 disabled
    wr(1, 1'b1, 140, 140, 20, 20, 0, 20000);
    fs();
    pix(1'b1, 150, 150, 1'b1, 0, 16290);
    wr(0, 1'b0, 60, 60, 180, 160, 0, 0);
    pix(1'b1, 150, 150, 1'b1, 0, 16290);
    fs();
    pix(1'b1, 150, 150, 1'b1, 1, 20210);

    // Mid-frame shadow write has no effect until frame_start
    wr(2, 1'b1, 0, 0, 10, 10, 0, 100);
    chk("pending_after_wr2", 32'(cfg_if.cfg_pending), 1);
    pix(1'b1, 5, 5, 1'b0, 0, 0);
    fs();
    pix(1'b1, 5, 5, 1'b1, 2, 155);

    // Write coincident with frame_start commits only at the next frame_start
    wr(3, 1'b1, 300, 300, 10, 10, 0, 500);
    set_cfg(2, 1'b1, 0, 0, 10, 10, 0, 200);
    cfg_if.cfg_we = 1'b1;
    frame_start   = 1'b1;
    idle();
    cfg_if.cfg_we = 1'b0;
    frame_start   = 1'b0;
    chk("pending_coincident", 32'(cfg_if.cfg_pending), 1);
    pix(1'b1, 305, 305, 1'b1, 3, 555);
    pix(1'b1, 5, 5, 1'b1, 2, 155);
    chk("pending_still_set", 32'(cfg_if.cfg_pending), 1);
    fs();
    chk("pending_after_fs2", 32'(cfg_if.cfg_pending), 0);
    pix(1'b1, 5, 5, 1'b1, 2, 255);

    // Right-edge clipping, zero width, valid low
    wr(3, 1'b1, 1000, 400, 50, 10, 0, 1000);
    wr(2, 1'b1, 0, 0, 0, 10, 0, 100);
    fs();
    pix(1'b1, 1023, 400, 1'b1, 3, 1023);
    pix(1'b1, 0, 400, 1'b0, 0, 0);
    pix(1'b1, 25, 400, 1'b0, 0, 0);
    pix(1'b1, 26, 400, 1'b0, 0, 0);
    pix(1'b1, 999, 400, 1'b0, 0, 0);
    pix(1'b1, 1010, 409, 1'b1, 3, 1460);
    pix(1'b1, 1010, 410, 1'b0, 0, 0);
    pix(1'b1, 0, 0, 1'b0, 0, 0);
    pix(1'b0, 1023, 400, 1'b0, 0, 0);

    // Asynchronous reset mid-stream
    pix(1'b1, 1023, 400, 1'b1, 3, 1023);
    idle();
    chk("pre_rst_hit", 32'(hit), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pixel_valid", 32'(pixel_valid), 0);
    chk("mid_rst_hit",         32'(hit), 0);
    chk("mid_rst_win_id",      32'(win_id), 0);
    chk("mid_rst_pixel_addr",  32'(pixel_addr), 0);
    chk("mid_rst_pending",     32'(cfg_if.cfg_pending), 0);
    sb.delete();
    #1 rst_n = 1'b1;
    pix(1'b1, 1023, 400, 1'b0, 0, 0);
    pix(1'b1, 5, 5, 1'b0, 0, 0);
    wr(0, 1'b1, 0, 0, 10, 10, 0, 7);
    pix(1'b1, 5, 5, 1'b0, 0, 0);
    fs();
    pix(1'b1, 5, 5, 1'b1, 0, 62);

    repeat (4) tick();
    chk("scoreboard_drained", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
